code_loader_gen2: RTL
=====================

# code_loader_gen2

Parametrised successor to the core's code/line loader. It sits between one core, that core's L1 data line and the shared data fabric. It handles three operation types:
- line write-back (L1 → fabric)
- line fill (fabric → L1)
- code-page load (fabric → command store)

It arbitrates for the fabric through the control fabric's request/grant pair. It double-buffers the command store so the core keeps executing from the active bank while the next page loads.

## Interface
Parameters:
- DATA_W, 8, segment/word width
- LINE_WORDS, 4, L1 line length in words; multiple of 4, ≥4
- PAGE_DEPTH, 512, commands per code page; even, power of 2
- N, 1, unit number presented to the control fabric

Ports:
- CLK_B  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high
- WRITE, READ, CALL, NEXT_PAGE  in  1 each  single-cycle operation strobes from core
- SA, SB, SC, IP  in  DATA_W each  operation address, sampled at accept
- BUSY  out  1  operation in progress
- DROP  out  1  one-cycle pulse: strobe arrived while BUSY
- ABORT  out  1  one-cycle pulse: grant lost mid-operation
- PAGE_READY  out  1  one-cycle pulse: bank swap done
- CMD_IDX  in  log2(PAGE_DEPTH)  command index into active bank
- COMMAND  out  2*DATA_W  registered command from active bank
- L1ADR  out  log2(LINE_WORDS)  L1 word address
- L1RD_EN, L1WR_EN  out  1 each  L1 read/write strobes
- L1_WDATA  out  DATA_W  L1 write data
- L1_RDATA  in  DATA_W  L1 read data, valid one cycle after L1RD_EN
- NUMBER_UNIT  out  4  constant N
- REQUEST  out  1  fabric ownership request
- GRANT  in  1  fabric ownership granted
- FD_ADDR  out  4*DATA_W  {SA,SB,SC,IP} latched at accept
- FD_ADDR_VALID, FD_WVALID, FD_RREQ  out  1 each  fabric address/write/read phases
- FD_WDATA  out  4*DATA_W  write beat; word 0 in the MSBs
- FD_READY  in  1  fabric accepts address or write beat
- FD_RVALID  in  1  read beat valid
- FD_RDATA  in  4*DATA_W  read beat

Reset values: all outputs 0 except NUMBER_UNIT=N and COMMAND=0. After reset the active bank is bank 0; both banks are left uninitialised.

## Operation
- Accept occurs only in IDLE.
  - Priority: WRITE > READ > CALL > NEXT_PAGE.
  - Lower-priority strobes arriving in the same cycle are discarded without DROP.
  - Any strobe while BUSY=1 is ignored and pulses DROP the next cycle.
- States: IDLE, CAPTURE, REQ, ADDR, WBEAT, RBEAT, FILL, LOAD, DONE.
- WRITE path: IDLE→CAPTURE→REQ→ADDR→WBEAT→DONE.
  - CAPTURE reads LINE_WORDS words (L1ADR 0..LINE_WORDS-1, one per cycle) into the line buffer.
  - WBEAT sends LINE_WORDS/4 beats, four words each, ascending.
- READ path: IDLE→REQ→ADDR→RBEAT→FILL→DONE.
  - RBEAT collects LINE_WORDS/4 beats.
  - FILL writes the buffer to L1, one word per cycle, ascending.
  - REQUEST drops on entry to FILL.
- CALL/NEXT_PAGE path: IDLE→REQ→ADDR→LOAD→DONE.
  - LOAD writes PAGE_DEPTH/2 beats into the inactive bank.
  - Each beat stores two commands at idx k and k+1: {w0,w1} at k, {w2,w3} at k+1.
  - k starts at 0 and increments by 2.
  - On the final beat, the active bank toggles and PAGE_READY pulses in DONE.
- REQ: REQUEST=1 until GRANT=1. REQUEST then stays high through ADDR, WBEAT/RBEAT/LOAD.
- ADDR: FD_ADDR_VALID=1 until FD_READY; the transfer occurs on the cycle both are high.
- WBEAT: a beat advances when FD_WVALID & FD_READY.
- RBEAT/LOAD: FD_RREQ=1; a beat is captured on FD_RVALID.
- DONE: one cycle, BUSY=0 on exit, return to IDLE.
- GRANT low during ADDR/WBEAT/RBEAT/LOAD:
  - Next state IDLE, ABORT pulses.
  - Bank is not swapped; L1 is not written.
  - The partial line/page is discarded.
- RESET mid-operation: immediate return to IDLE and all outputs to reset values. Active bank returns to 0.

## Timing
- Strobe at edge n → BUSY=1 from n+1. CAPTURE or REQ begins at n+1.
- CAPTURE: LINE_WORDS+1 cycles, including the final data-return cycle.
- FILL: LINE_WORDS cycles.
- Fastest WRITE with GRANT and FD_READY tied high: 1 + (LINE_WORDS+1) + 1 + 1 + LINE_WORDS/4 + 1 cycles from accept to BUSY=0.
- COMMAND: registered; CMD_IDX at edge n → data valid after edge n+1.
- Bank swap: takes effect on the DONE edge. COMMAND reflects the new bank from the following CMD_IDX sample.
- Beat counters wrap only at their terminal count. No beats are accepted beyond the terminal count; extra FD_RVALID is ignored.

## Test plan
- Reset held 3 cycles with WRITE high → BUSY=0, REQUEST=0, no L1 strobes, NUMBER_UNIT=N.
- WRITE with L1 words 0x11,0x22,0x33,0x44 and SA..IP=01,02,03,04 → FD_ADDR=0x01020304; one beat FD_WDATA=0x11223344; BUSY drops after DONE.
- READ, fabric returns 0xA1B2C3D4 with FD_RVALID after 3 idle cycles → L1 writes A1,B2,C3,D4 at L1ADR 0..3 on consecutive cycles.
- CALL with a page where beat k carries {k,k+1,k,k+1} (low byte), GRANT delayed 5 cycles → PAGE_READY pulses once; CMD_IDX=6 returns 0x0304 from the new bank.
- GRANT dropped after 10 LOAD beats → ABORT pulse; active bank unchanged; COMMAND still returns old-page data.
- WRITE and READ in the same cycle, then CALL while BUSY → WRITE path taken; READ discarded; DROP pulses once for CALL.

Source files
------------

// File: rtl/code_loader_gen2.sv
// code_loader_gen2: moves L1 lines between the core's L1 and the shared data
// fabric, and loads code pages into a double-buffered command store so the
// core keeps executing from the active bank while the next page streams in.
module code_loader_gen2 #(
  parameter int DATA_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int PAGE_DEPTH = 512,
  parameter int N          = 1
) (
  input  logic                          CLK_B,
  input  logic                          RESET,
  input  logic                          WRITE,
  input  logic                          READ,
  input  logic                          CALL,
  input  logic                          NEXT_PAGE,
  input  logic [DATA_W-1:0]             SA,
  input  logic [DATA_W-1:0]             SB,
  input  logic [DATA_W-1:0]             SC,
  input  logic [DATA_W-1:0]             IP,
  output logic                          BUSY,
  output logic                          DROP,
  output logic                          ABORT,
  output logic                          PAGE_READY,
  input  logic [$clog2(PAGE_DEPTH)-1:0] CMD_IDX,
  output logic [2*DATA_W-1:0]           COMMAND,
  output logic [$clog2(LINE_WORDS)-1:0] L1ADR,
  output logic                          L1RD_EN,
  output logic                          L1WR_EN,
  output logic [DATA_W-1:0]             L1_WDATA,
  input  logic [DATA_W-1:0]             L1_RDATA,
  output logic [3:0]                    NUMBER_UNIT,
  output logic                          REQUEST,
  input  logic                          GRANT,
  output logic [4*DATA_W-1:0]           FD_ADDR,
  output logic                          FD_ADDR_VALID,
  output logic                          FD_WVALID,
  output logic                          FD_RREQ,
  output logic [4*DATA_W-1:0]           FD_WDATA,
  input  logic                          FD_READY,
  input  logic                          FD_RVALID,
  input  logic [4*DATA_W-1:0]           FD_RDATA
);

  localparam int IDX_W  = $clog2(PAGE_DEPTH);
  localparam int ADR_W  = $clog2(LINE_WORDS);
  localparam int BEATS  = LINE_WORDS / 4;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int BEAT_W = 4 * DATA_W;
  localparam int CMD_W  = 2 * DATA_W;
  // One counter serves CAPTURE (0..LINE_WORDS), beats and LOAD (0..PAGE_DEPTH-2).
  localparam int CNT_W  = $clog2(PAGE_DEPTH + LINE_WORDS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CAPTURE, S_REQ, S_ADDR, S_WBEAT, S_RBEAT, S_FILL, S_LOAD, S_DONE
  } state_e;

  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_LOAD} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;   // word 0 ends up in the MSBs
  logic [BEAT_W-1:0]  addr_q, addr_d;
  logic               active_q, active_d;
  logic               abort_q, abort_d;
  logic               drop_q, drop_d;
  logic [CMD_W-1:0]   cmd_q;
  logic               mem_we;

  // Each page beat carries an even/odd command pair, so the store is split
  // into even and odd halves; the bank select is the address MSB.
  logic [CMD_W-1:0]   even_q [PAGE_DEPTH];
  logic [CMD_W-1:0]   odd_q  [PAGE_DEPTH];
  logic [IDX_W-1:0]   wr_addr, rd_addr;

  assign wr_addr = {~active_q, cnt_q[IDX_W-1:1]};
  assign rd_addr = {active_q, CMD_IDX[IDX_W-1:1]};

  // Next-state, datapath updates and Moore-style outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    line_d        = line_q;
    addr_d        = addr_q;
    active_d      = active_q;
    abort_d       = 1'b0;
    drop_d        = (state_q != S_IDLE) && (WRITE || READ || CALL || NEXT_PAGE);
    mem_we        = 1'b0;
    L1ADR         = '0;
    L1RD_EN       = 1'b0;
    L1WR_EN       = 1'b0;
    L1_WDATA      = '0;
    REQUEST       = 1'b0;
    FD_ADDR_VALID = 1'b0;
    FD_WVALID     = 1'b0;
    FD_RREQ       = 1'b0;
    FD_WDATA      = '0;
    PAGE_READY    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (WRITE || READ || CALL || NEXT_PAGE) begin
          addr_d = {SA, SB, SC, IP};
          if (WRITE) begin
            op_d    = OP_WRITE;
            state_d = S_CAPTURE;
          end else if (READ) begin
            op_d    = OP_READ;
            state_d = S_REQ;
          end else begin
            op_d    = OP_LOAD;
            state_d = S_REQ;
          end
        end
      end
      S_CAPTURE: begin
        // Reads are issued for cnt 0..LINE_WORDS-1; data trails by one cycle.
        if (cnt_q != CNT_W'(LINE_WORDS)) begin
          L1RD_EN = 1'b1;
          L1ADR   = cnt_q[ADR_W-1:0];
        end
        if (cnt_q != '0) line_d = (line_q << DATA_W) | LINE_W'(L1_RDATA);
        if (cnt_q == CNT_W'(LINE_WORDS)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        REQUEST = 1'b1;
        if (GRANT) state_d = S_ADDR;
      end
      S_ADDR: begin
        REQUEST       = 1'b1;
        FD_ADDR_VALID = 1'b1;
        if (!GRANT) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (FD_READY) begin
          unique case (op_q)
            OP_WRITE: state_d = S_WBEAT;
            OP_READ:  state_d = S_RBEAT;
            default:  state_d = S_LOAD;
          endcase
        end
      end
      S_WBEAT: begin
        REQUEST   = 1'b1;
        FD_WVALID = 1'b1;
        FD_WDATA  = line_q[LINE_W-1 -: BEAT_W];
        if (!GRANT) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (FD_READY) begin
          line_d = line_q << BEAT_W;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RBEAT: begin
        REQUEST = 1'b1;
        FD_RREQ = 1'b1;
        if (!GRANT) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (FD_RVALID) begin
          line_d = (line_q << BEAT_W) | LINE_W'(FD_RDATA);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_FILL: begin
        L1WR_EN  = 1'b1;
        L1ADR    = cnt_q[ADR_W-1:0];
        L1_WDATA = line_q[LINE_W-1 -: DATA_W];
        line_d   = line_q << DATA_W;
        if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        REQUEST = 1'b1;
        FD_RREQ = 1'b1;
        if (!GRANT) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (FD_RVALID) begin
          mem_we = 1'b1;
          if (cnt_q == CNT_W'(PAGE_DEPTH - 2)) begin
            active_d = ~active_q;
            cnt_d    = '0;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(2);
          end
        end
      end
      S_DONE: begin
        PAGE_READY = (op_q == OP_LOAD);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK_B) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= OP_WRITE;
      cnt_q    <= '0;
      addr_q   <= '0;
      active_q <= 1'b0;
      abort_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      active_q <= active_d;
      abort_q  <= abort_d;
      drop_q   <= drop_d;
    end
  end

  // Line buffer: pure datapath, every operation overwrites it completely.
  always_ff @(posedge CLK_B) begin
    line_q <= line_d;
  end

  // Command store writes into the inactive bank during LOAD.
  always_ff @(posedge CLK_B) begin
    // NOTE: the command store has no reset; its contents are only meaningful
    // after a completed page load, and a reset port would prevent RAM mapping.
    if (mem_we && !RESET) begin
      even_q[wr_addr] <= FD_RDATA[BEAT_W-1 -: CMD_W];
      odd_q[wr_addr]  <= FD_RDATA[CMD_W-1:0];
    end
  end

  // Registered command read from the active bank.
  always_ff @(posedge CLK_B) begin
    if (RESET) cmd_q <= '0;
    else       cmd_q <= CMD_IDX[0] ? odd_q[rd_addr] : even_q[rd_addr];
  end

  assign BUSY        = (state_q != S_IDLE);
  assign DROP        = drop_q;
  assign ABORT       = abort_q;
  assign COMMAND     = cmd_q;
  assign FD_ADDR     = addr_q;
  assign NUMBER_UNIT = 4'(N);

endmodule
